// File: rtl/m_button_input.sv
// -----------------------------------------------------------------------------
// m_button_input
//
// Purpose:
//   Turns three raw, bouncing push-buttons (INC, DEC, OK) into clean one-cycle
//   command pulses for the game controller. Each button is synchronized,
//   debounced, and edge-detected. Presses are queued in per-button pending
//   bits and drained one per cycle in priority order OK > DEC > INC, so
//   simultaneous presses are serialized and never lost.
//
// Optional feature (compile-time macro):
//   AUTO_REPEAT_EN - when defined, holding INC or DEC re-issues its command
//                    REPEAT_DELAY cycles after the press and then every
//                    REPEAT_PERIOD cycles while the button stays down.
//                    OK never repeats. When undefined, no repeat logic exists.
//
// Parameters:
//   DEBOUNCE_CYCLES - stable cycles required before a level change (1..2^20-1)
//   REPEAT_DELAY    - cycles from debounced press to first auto-repeat
//   REPEAT_PERIOD   - cycles between subsequent auto-repeats
//
// Ports:
//   w_clk        in   1  single clock, rising edge
//   w_rst_n      in   1  asynchronous active-low reset
//   i_btn        in   3  raw buttons, bit0 INC, bit1 DEC, bit2 OK, 1 = pressed
//   o_user_input out  4  one-hot command pulse: 0001 INC, 0010 DEC, 0100 OK
//   o_btn_level  out  3  debounced button levels, same order as i_btn
// -----------------------------------------------------------------------------
module m_button_input #(
   parameter int unsigned DEBOUNCE_CYCLES = 100000,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_PERIOD   = 10000000
) (
   input  logic       w_clk,
   input  logic       w_rst_n,
   input  logic [2:0] i_btn,
   output logic [3:0] o_user_input,
   output logic [2:0] o_btn_level
);

   // Counter just wide enough to hold DEBOUNCE_CYCLES-1.
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam int BTN_INC = 0;
   localparam int BTN_DEC = 1;
   localparam int BTN_OK  = 2;

   // ------------------------------------------------------------------------
   // Two-flop synchronizer
   // ------------------------------------------------------------------------
   logic [2:0] sync1_q;
   logic [2:0] sync2_q;

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         sync1_q <= 3'b000;
         sync2_q <= 3'b000;
      end else begin
         sync1_q <= i_btn;
         sync2_q <= sync1_q;
      end
   end

   // ------------------------------------------------------------------------
   // Debounce: a level only changes after the synchronized input has
   // disagreed with it for DEBOUNCE_CYCLES consecutive edges.
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];
   logic [2:0]       level_q;
   logic [2:0]       level_d;

   always_comb begin
      level_d = level_q;
      for (int b = 0; b < 3; b++) begin
         cnt_d[b] = '0;
         if (sync2_q[b] != level_q[b]) begin
            if (cnt_q[b] == DEB_LAST) begin
               level_d[b] = sync2_q[b];
            end else begin
               cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         level_q <= 3'b000;
         for (int b = 0; b < 3; b++) begin
            cnt_q[b] <= '0;
         end
      end else begin
         level_q <= level_d;
         for (int b = 0; b < 3; b++) begin
            cnt_q[b] <= cnt_d[b];
         end
      end
   end

   // Press events are taken from the next-state so the pending bit is set on
   // the same edge the level rises.
   logic [2:0] press_evt;
   assign press_evt = level_d & ~level_q;

   // ------------------------------------------------------------------------
   // Auto-repeat for INC and DEC
   // ------------------------------------------------------------------------
   logic [2:0] repeat_evt;

`ifdef AUTO_REPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
   localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

   logic [REP_W-1:0] rep_cnt_q [2];
   logic [REP_W-1:0] rep_cnt_d [2];
   logic [1:0]       rep_first_q;
   logic [1:0]       rep_first_d;
   logic [1:0]       rep_fire;

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         rep_cnt_d[b]   = '0;
         rep_first_d[b] = 1'b1;
         rep_fire[b]    = 1'b0;
         if (level_q[b]) begin
            rep_first_d[b] = rep_first_q[b];
            if (rep_cnt_q[b] == (rep_first_q[b] ? REP_FIRST : REP_NEXT)) begin
               // A repeat that lands on the release edge is dropped: the
               // button is no longer considered held.
               rep_fire[b]    = level_d[b];
               rep_first_d[b] = 1'b0;
            end else begin
               rep_cnt_d[b] = rep_cnt_q[b] + REP_W'(1);
            end
         end
      end
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         rep_first_q <= 2'b11;
         for (int b = 0; b < 2; b++) begin
            rep_cnt_q[b] <= '0;
         end
      end else begin
         rep_first_q <= rep_first_d;
         for (int b = 0; b < 2; b++) begin
            rep_cnt_q[b] <= rep_cnt_d[b];
         end
      end
   end

   assign repeat_evt = {1'b0, rep_fire};
`else
   assign repeat_evt = 3'b000;
`endif

   // ------------------------------------------------------------------------
   // Pending queue and priority drain (OK > DEC > INC)
   // ------------------------------------------------------------------------
   logic [2:0] pend_q;
   logic [2:0] pend_d;
   logic [2:0] grant;
   logic [3:0] user_q;
   logic [3:0] user_d;

   always_comb begin
      grant = 3'b000;
      if (pend_q[BTN_OK]) begin
         grant[BTN_OK] = 1'b1;
      end else if (pend_q[BTN_DEC]) begin
         grant[BTN_DEC] = 1'b1;
      end else if (pend_q[BTN_INC]) begin
         grant[BTN_INC] = 1'b1;
      end
   end

   // New events are OR-ed in after the clear so a set wins over a drain.
   always_comb begin
      pend_d = (pend_q & ~grant) | press_evt | repeat_evt;
      user_d = {1'b0, grant};
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         pend_q <= 3'b000;
         user_q <= 4'b0000;
      end else begin
         pend_q <= pend_d;
         user_q <= user_d;
      end
   end

   assign o_user_input = user_q;
   assign o_btn_level  = level_q;

endmodule

// File: doc/m_button_input.md
M_BUTTON_INPUT -- requirements
Module: m_button_input

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100000, meaning the number of stable cycles required before a debounced level change (legal range 1..2^20-1).
REQ-002 SHALL have parameter REPEAT_DELAY, default 50000000, meaning the cycles from a debounced press to the first auto-repeat.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 10000000, meaning the cycles between subsequent auto-repeats.
REQ-004 SHALL have port w_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port w_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port i_btn, input, 3 bits: raw asynchronous buttons; bit0 INC, bit1 DEC, bit2 OK; 1 = pressed.
REQ-007 SHALL have port o_user_input, output, 4 bits: one-hot command pulse for the game controller; 4'b0001 INC, 4'b0010 DEC, 4'b0100 OK; bit3 is constant 0.
REQ-008 SHALL have port o_btn_level, output, 3 bits: debounced button levels, same bit order as i_btn.

Function
REQ-009 Each i_btn bit SHALL pass through a 2-flop synchronizer (sync2 = second flop) before any other logic.
REQ-010 Per button, on an edge where sync2 != level: if cnt == DEBOUNCE_CYCLES-1, then level <= sync2 and cnt <= 0; otherwise cnt <= cnt+1.
REQ-011 Per button, on an edge where sync2 == level, cnt SHALL be cleared to 0; any glitch therefore restarts the count.
REQ-012 On the edge where level goes 0->1, that button's pending bit SHALL be set; a 1->0 transition SHALL NOT generate a command.
REQ-013 Each edge, the registered o_user_input SHALL be loaded with the one-hot of the highest-priority pending bit (OK > DEC > INC), or 0 if none is pending, and that pending bit SHALL be cleared.
REQ-014 At most one o_user_input bit SHALL be high in any cycle, and each pulse SHALL last exactly one cycle.
REQ-015 Simultaneous presses SHALL be emitted on consecutive cycles in priority order; none is dropped.
REQ-016 A set event and a clear event on the same pending bit in the same edge SHALL leave the bit set.
REQ-017 Clean-press latency: raw 0->1 first sampled at edge k, held stable -> pulse high during the cycle after edge k+DEBOUNCE_CYCLES+2.
REQ-018 Pending bits SHALL survive button release; an accepted press is always delivered.
REQ-019 o_btn_level SHALL equal the level registers directly, with no extra delay.

Reset
REQ-020 While w_rst_n = 0, all flops SHALL clear asynchronously: synchronizers, cnt, level, pending, repeat counters, o_user_input = 4'b0000, o_btn_level = 3'b000.
REQ-021 A button held through reset release SHALL be treated as a new press and produce exactly one pulse at the REQ-017 latency, measured from the first edge after deassertion.
REQ-022 Reset asserted mid-debounce or with pulses pending SHALL discard that state; no pulse is emitted after reset for presses already released.

Configuration
REQ-023 Macro AUTO_REPEAT_EN: when defined, a per-button repeat counter for INC and DEC only SHALL run while that level = 1.
REQ-024 With AUTO_REPEAT_EN defined, the counter SHALL set the button's pending bit REPEAT_DELAY cycles after the level rise, then every REPEAT_PERIOD cycles; it SHALL clear when the level falls.
REQ-025 With AUTO_REPEAT_EN defined, OK SHALL never auto-repeat.
REQ-026 With AUTO_REPEAT_EN undefined, no repeat logic SHALL be instantiated and each press SHALL yield exactly one pulse.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-027 Clean INC press: i_btn 000->001 first sampled at edge 10, held -> o_user_input = 0001 for exactly the one cycle after edge 16; o_btn_level = 001 after edge 15.
REQ-028 Bounce: i_btn bit0 toggles 1,0,1 at 2-cycle intervals, then holds -> exactly one 0001 pulse, at 6 edges after the last toggle is sampled.
REQ-029 Simultaneous: i_btn 000->111 at edge 10 -> 0100 after edge 16, 0010 after edge 17, 0001 after edge 18, then 0000.
REQ-030 Reset mid-debounce: press OK at edge 10, assert w_rst_n = 0 at edge 12, release at edge 14 with OK still held -> all outputs 0 during reset; a single 0100 pulse 7 edges after reset release.
REQ-031 AUTO_REPEAT_EN, DEC held 60 cycles -> 0010 pulses at the press, press+20, +28, +36, +44, +52; none after release; with the macro undefined, one pulse only.
